// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment scanner with prescaler, blanking and frame strobe.
// Optional anti-ghosting guard cycle at each slot start when SEG_SCAN_GUARD_EN is defined.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7,
  parameter int TICK_DIV   = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*SEG_W-1:0]   seg_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [SEG_W-1:0]              seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wrapped_q, wrapped_d;
  logic                  slot_end, last_digit, guard, blank, fs_d;
  logic [SEG_W-1:0]      seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  always_comb begin
    slot_end   = cnt_q == CW'(TICK_DIV - 1);
    last_digit = idx_q == IW'(NUM_DIGITS - 1);
    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    idx_d      = slot_end ? (last_digit ? '0 : idx_q + IW'(1)) : idx_q;
    wrapped_d  = wrapped_q | (slot_end & last_digit);
`ifdef SEG_SCAN_GUARD_EN
    guard      = cnt_q == '0;
`else
    guard      = 1'b0;
`endif
    blank      = !digit_en[idx_q] || guard;
    an_d       = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d      = blank ? '1 : seg_in[idx_q*SEG_W +: SEG_W];
    fs_d       = (idx_q == '0) && (cnt_q == '0) && wrapped_q;
  end

  // Outputs are registered from the current state, so they trail cnt/idx by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      wrapped_q   <= 1'b0;
      seg_out     <= '1;
      an_out      <= '1;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wrapped_q   <= wrapped_d;
      seg_out     <= seg_d;
      an_out      <= an_d;
      digit_idx   <= idx_q;
      frame_start <= fs_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for a 4-digit and a 3-digit scanner with TICK_DIV=4.
module tb_seg_scan_mux;
  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] seg_in;
  logic [3:0]  digit_en;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        frame_start;
  logic [20:0] seg_in3;
  logic [2:0]  digit_en3;
  logic [6:0]  seg_out3;
  logic [2:0]  an_out3;
  logic [1:0]  digit_idx3;
  logic        frame_start3;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] idx;
    logic       fs;
    logic [6:0] seg3;
    logic [2:0] an3;
    logic [1:0] idx3;
    logic       fs3;
  } exp_t;

  exp_t q[$];
  int   n_tot = 0;
  int   n_bad = 0;
  int   t = 0;
  int   last_fs3 = -1;

  seg_scan_mux #(.NUM_DIGITS(4), .SEG_W(7), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_en(digit_en),
    .seg_out(seg_out), .an_out(an_out), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  seg_scan_mux #(.NUM_DIGITS(3), .SEG_W(7), .TICK_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .seg_in(seg_in3), .digit_en(digit_en3),
    .seg_out(seg_out3), .an_out(an_out3), .digit_idx(digit_idx3), .frame_start(frame_start3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Expected outputs for the n-th edge after reset release, from slot arithmetic.
  function automatic exp_t model(input int n);
    exp_t e;
    int   i, c, i3;
    logic g, b;
    i  = (n / 4) % 4;
    i3 = (n / 4) % 3;
    c  = n % 4;
`ifdef SEG_SCAN_GUARD_EN
    g = (c == 0);
`else
    g = 1'b0;
`endif
    b      = !digit_en[i] || g;
    e.an   = b ? 4'hF : ~(4'b0001 << i);
    e.seg  = b ? 7'h7F : seg_in[i*7 +: 7];
    e.idx  = 2'(i);
    e.fs   = (n % 16 == 0) && (n >= 16);
    b      = !digit_en3[i3] || g;
    e.an3  = b ? 3'h7 : ~(3'b001 << i3);
    e.seg3 = b ? 7'h7F : seg_in3[i3*7 +: 7];
    e.idx3 = 2'(i3);
    e.fs3  = (n % 12 == 0) && (n >= 12);
    return e;
  endfunction

  task automatic tick;
    exp_t e;
    @(posedge clk);
    q.push_back(model(t));
    t++;
    @(negedge clk);
    e = q.pop_front();
    chk("seg", 32'(seg_out), 32'(e.seg));
    chk("an", 32'(an_out), 32'(e.an));
    chk("idx", 32'(digit_idx), 32'(e.idx));
    chk("fs", 32'(frame_start), 32'(e.fs));
    chk("seg3", 32'(seg_out3), 32'(e.seg3));
    chk("an3", 32'(an_out3), 32'(e.an3));
    chk("idx3", 32'(digit_idx3), 32'(e.idx3));
    chk("fs3", 32'(frame_start3), 32'(e.fs3));
    chk("an_onehot", 32'($countones(~an_out) <= 1), 32'd1);
    chk("idx3_range", 32'(digit_idx3 < 2'd3), 32'd1);
    if (frame_start3) begin
      if (last_fs3 >= 0) chk("fs3_period", 32'(t - last_fs3), 32'd12);
      last_fs3 = t;
    end
  endtask

  task automatic chk_rst;
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_an3", 32'(an_out3), 32'h7);
    chk("rst_seg3", 32'(seg_out3), 32'h7F);
  endtask

  initial begin
    rst       = 1'b1;
    digit_en  = 4'b1111;
    seg_in    = {7'h30, 7'h24, 7'h79, 7'h40};
    digit_en3 = 3'b111;
    seg_in3   = {7'h12, 7'h34, 7'h56};
    repeat (3) begin
      @(negedge clk);
      chk_rst();
    end
    rst = 1'b0;
    repeat (40) tick();
    digit_en = 4'b1010;
    repeat (20) tick();
    seg_in = {7'h00, 7'h11, 7'h22, 7'h33};
    digit_en3 = 3'b010;
    repeat (6) tick();
    digit_en  = 4'b1111;
    digit_en3 = 3'b111;
    while (t % 16 != 10) tick();
    #2 rst = 1'b1;
    #1 chk_rst();
    repeat (2) begin
      @(negedge clk);
      chk_rst();
    end
    rst = 1'b0;
    t = 0;
    last_fs3 = -1;
    repeat (30) tick();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
